// File: rtl/tipi_nib_seq_pkg.sv
// -----------------------------------------------------------------------------
// tipi_nib_seq_pkg
// Purpose : Shared definitions for the TIPI Pi-side nibble sequencer:
//           nibble-bus command codes, FSM state encodings and a small
//           command decoding helper.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package tipi_nib_seq_pkg;

  // Command nibbles sent by the Pi as the first strobe of a frame.
  localparam logic [3:0] CMD_NOP      = 4'h0;
  localparam logic [3:0] CMD_READ_TD  = 4'h1;
  localparam logic [3:0] CMD_READ_TC  = 4'h2;
  localparam logic [3:0] CMD_WRITE_RD = 4'h5;
  localparam logic [3:0] CMD_WRITE_RC = 4'h6;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_HI = 3'd1,
    ST_RD_LO = 3'd2,
    ST_WR_HI = 3'd3,
    ST_WR_LO = 3'd4
  } state_t;

  // True for any command nibble the sequencer understands (NOP included).
  function automatic logic cmd_is_known(input logic [3:0] cmd);
    return (cmd == CMD_NOP)      || (cmd == CMD_READ_TD)  ||
           (cmd == CMD_READ_TC)  || (cmd == CMD_WRITE_RD) ||
           (cmd == CMD_WRITE_RC);
  endfunction

endpackage

// File: rtl/tipi_nib_seq_sync_8bit.sv
// -----------------------------------------------------------------------------
// sync_8bit
// Purpose : Multi-stage flip-flop synchroniser for an 8-bit quasi-static
//           value (the TI-side TD/TC latches) into the Pi clock domain.
// Ports   :
//   i_clk   in  1  destination clock
//   i_srst  in  1  synchronous active-high clear of every stage
//   i_d     in  8  value from the foreign domain
//   o_q     out 8  synchronised value (last stage)
// -----------------------------------------------------------------------------
module sync_8bit #(
  parameter int STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic [7:0] i_d,
  output logic [7:0] o_q
);

  // Fewer than two stages gives no metastability protection; clamp.
  localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

  logic [7:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_stage[0] <= 8'h00;
    end else begin
      r_stage[0] <= i_d;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      always_ff @(posedge i_clk) begin
        if (i_srst) begin
          r_stage[gi] <= 8'h00;
        end else begin
          r_stage[gi] <= r_stage[gi-1];
        end
      end
    end
  endgenerate

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/tipi_nib_seq.sv
// -----------------------------------------------------------------------------
// tipi_nib_seq
// Purpose : Pi-side nibble-bus sequencer for the TIPI register file. Frames
//           3-strobe transfers (command, hi nibble, lo nibble) to read the
//           TI-written TD/TC latches and write the Pi-owned RD/RC registers.
//           Raises r_attn while TC differs from the last TC value read.
// Ports   :
//   r_clk      in  1  Pi-supplied clock
//   r_rst      in  1  synchronous active-high reset
//   r_stb      in  1  one-cycle nibble strobe
//   r_nib_in   in  4  nibble from the Pi
//   r_nib_out  out 4  nibble to the Pi (registered)
//   r_nib_oe   out 1  pin driver enable (registered)
//   r_attn     out 1  synced TC differs from last TC read
//   r_err      out 1  one-cycle pulse: bad command or timeout abort
//   busy       out 1  sequencer not idle
//   ti_td      in  8  TD latch (TI domain)
//   ti_tc      in  8  TC latch (TI domain)
//   rd_reg     out 8  RD register to TI read mux
//   rc_reg     out 8  RC register to TI read mux
// -----------------------------------------------------------------------------
module tipi_nib_seq
  import tipi_nib_seq_pkg::*;
#(
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic       r_clk,
  input  logic       r_rst,
  input  logic       r_stb,
  input  logic [3:0] r_nib_in,
  output logic [3:0] r_nib_out,
  output logic       r_nib_oe,
  output logic       r_attn,
  output logic       r_err,
  output logic       busy,
  input  logic [7:0] ti_td,
  input  logic [7:0] ti_tc,
  output logic [7:0] rd_reg,
  output logic [7:0] rc_reg
);

  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  logic [7:0]    w_td_s;
  logic [7:0]    w_tc_s;
  logic          w_timeout;

  state_t        r_state;
  logic [7:0]    r_shadow;
  logic [7:0]    r_tc_seen;
  logic [3:0]    r_hi;
  logic          r_sel_rc;
  logic [CW-1:0] r_cnt;

  sync_8bit #(.STAGES(SYNC_STAGES)) u_sync_td (
    .i_clk  (r_clk),
    .i_srst (r_rst),
    .i_d    (ti_td),
    .o_q    (w_td_s)
  );

  sync_8bit #(.STAGES(SYNC_STAGES)) u_sync_tc (
    .i_clk  (r_clk),
    .i_srst (r_rst),
    .i_d    (ti_tc),
    .o_q    (w_tc_s)
  );

  // A strobe on the terminal count cycle takes priority over the abort.
  assign w_timeout = (r_state != ST_IDLE) && !r_stb && (r_cnt == CNT_LAST);

  assign busy   = (r_state != ST_IDLE);
  assign r_attn = (w_tc_s != r_tc_seen);

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_state   <= ST_IDLE;
      r_shadow  <= 8'h00;
      r_tc_seen <= 8'h00;
      r_hi      <= 4'h0;
      r_sel_rc  <= 1'b0;
      r_cnt     <= '0;
      r_nib_out <= 4'h0;
      r_nib_oe  <= 1'b0;
      r_err     <= 1'b0;
      rd_reg    <= 8'h00;
      rc_reg    <= 8'h00;
    end else begin
      r_err <= 1'b0;

      if ((r_state == ST_IDLE) || r_stb || w_timeout) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_timeout) begin
        // Abort: a partially received write is discarded.
        r_state   <= ST_IDLE;
        r_err     <= 1'b1;
        r_nib_oe  <= 1'b0;
        r_nib_out <= 4'h0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_stb) begin
              if (!cmd_is_known(r_nib_in)) begin
                r_err <= 1'b1;
              end else begin
                case (r_nib_in)
                  CMD_READ_TD: begin
                    r_shadow  <= w_td_s;
                    r_nib_out <= w_td_s[7:4];
                    r_nib_oe  <= 1'b1;
                    r_state   <= ST_RD_HI;
                  end
                  CMD_READ_TC: begin
                    r_shadow  <= w_tc_s;
                    r_tc_seen <= w_tc_s;
                    r_nib_out <= w_tc_s[7:4];
                    r_nib_oe  <= 1'b1;
                    r_state   <= ST_RD_HI;
                  end
                  CMD_WRITE_RD: begin
                    r_sel_rc <= 1'b0;
                    r_state  <= ST_WR_HI;
                  end
                  CMD_WRITE_RC: begin
                    r_sel_rc <= 1'b1;
                    r_state  <= ST_WR_HI;
                  end
                  default: begin
                    // CMD_NOP: nothing to do.
                  end
                endcase
              end
            end
          end

          ST_RD_HI: begin
            if (r_stb) begin
              r_nib_out <= r_shadow[3:0];
              r_state   <= ST_RD_LO;
            end
          end

          ST_RD_LO: begin
            if (r_stb) begin
              r_nib_out <= 4'h0;
              r_nib_oe  <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end

          ST_WR_HI: begin
            if (r_stb) begin
              r_hi    <= r_nib_in;
              r_state <= ST_WR_LO;
            end
          end

          ST_WR_LO: begin
            if (r_stb) begin
              if (r_sel_rc) begin
                rc_reg <= {r_hi, r_nib_in};
              end else begin
                rd_reg <= {r_hi, r_nib_in};
              end
              r_state <= ST_IDLE;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tipi_nib_seq.sv
module tb_tipi_nib_seq;

  localparam int TIMEOUT = 64;
  localparam int SYNC    = 2;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic       r_stb;
  logic [3:0] r_nib_in;
  logic [3:0] r_nib_out;
  logic       r_nib_oe;
  logic       r_attn;
  logic       r_err;
  logic       busy;
  logic [7:0] ti_td;
  logic [7:0] ti_tc;
  logic [7:0] rd_reg;
  logic [7:0] rc_reg;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       sel_rc;
    logic [7:0] val;
  } wr_t;

  logic [3:0] nib_q[$];
  wr_t        wr_q[$];
  logic [7:0] rd_m;
  logic [7:0] rc_m;

  tipi_nib_seq #(
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC)
  ) dut (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .r_stb     (r_stb),
    .r_nib_in  (r_nib_in),
    .r_nib_out (r_nib_out),
    .r_nib_oe  (r_nib_oe),
    .r_attn    (r_attn),
    .r_err     (r_err),
    .busy      (busy),
    .ti_td     (ti_td),
    .ti_tc     (ti_tc),
    .rd_reg    (rd_reg),
    .rc_reg    (rc_reg)
  );

  always #5 r_clk = ~r_clk;

  // Called at a negedge; drives one strobe cycle and returns at the next
  // negedge, where registered outputs already reflect the strobe.
  task automatic strobe(input logic [3:0] n);
    r_stb    = 1'b1;
    r_nib_in = n;
    @(negedge r_clk);
    r_stb    = 1'b0;
    r_nib_in = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  task automatic read_frame(input logic [3:0] cmd, input logic [7:0] exp_b,
                            input int gap, input string name);
    logic [3:0] e;
    strobe(cmd);
    nib_q.push_back(exp_b[7:4]);
    for (int i = 0; i <= gap; i++) begin
      checks++;
      if (r_nib_oe !== 1'b1) begin
        failures++;
        $display("FAIL %s_oe_hi got=%b exp=1", name, r_nib_oe);
      end
      if (i < gap) @(negedge r_clk);
    end
    e = nib_q.pop_front();
    checks++;
    if (r_nib_out !== e) begin
      failures++;
      $display("FAIL %s_hi got=%h exp=%h", name, r_nib_out, e);
    end
    strobe(4'hF);
    nib_q.push_back(exp_b[3:0]);
    e = nib_q.pop_front();
    checks++;
    if (r_nib_out !== e || r_nib_oe !== 1'b1) begin
      failures++;
      $display("FAIL %s_lo got=%h/oe%b exp=%h/oe1", name, r_nib_out, r_nib_oe, e);
    end
    strobe(4'h0);
    checks++;
    if (r_nib_oe !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end got=oe%b/busy%b exp=oe0/busy0", name, r_nib_oe, busy);
    end
    $display("read  cmd=%h data=%h", cmd, exp_b);
  endtask

  task automatic write_frame(input logic [3:0] cmd, input logic [7:0] val,
                             input string name);
    wr_t w;
    wr_q.push_back('{sel_rc: (cmd == 4'h6), val: val});
    strobe(cmd);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy got=%b exp=1", name, busy);
    end
    strobe(val[7:4]);
    strobe(val[3:0]);
    w = wr_q.pop_front();
    if (w.sel_rc) rc_m = w.val;
    else          rd_m = w.val;
    checks++;
    if (rd_reg !== rd_m || rc_reg !== rc_m || r_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_regs got=rd%h/rc%h/err%b exp=rd%h/rc%h/err0",
               name, rd_reg, rc_reg, r_err, rd_m, rc_m);
    end
    $display("write cmd=%h data=%h", cmd, val);
  endtask

  task automatic test_reset();
    r_rst = 1'b1; r_stb = 1'b0; r_nib_in = 4'h0;
    ti_td = 8'h00; ti_tc = 8'h00;
    rd_m = 8'h00; rc_m = 8'h00;
    idle(3);
    r_rst = 1'b0;
    idle(1);
    checks++;
    if (r_nib_out !== 4'h0 || r_nib_oe !== 1'b0 || r_attn !== 1'b0 ||
        r_err !== 1'b0 || busy !== 1'b0 || rd_reg !== 8'h00 || rc_reg !== 8'h00) begin
      failures++;
      $display("FAIL reset got=nib%h oe%b attn%b err%b busy%b rd%h rc%h exp=all zero",
               r_nib_out, r_nib_oe, r_attn, r_err, busy, rd_reg, rc_reg);
    end
    $display("reset done");
  endtask

  task automatic test_read_td();
    ti_td = 8'hA5;
    idle(SYNC);
    read_frame(4'h1, 8'hA5, 2, "read_td");
  endtask

  task automatic test_write_rd();
    write_frame(4'h5, 8'h3C, "write_rd");
  endtask

  task automatic test_attn();
    logic [3:0] e;
    ti_tc = 8'h81;
    idle(1);
    checks++;
    if (r_attn !== 1'b0) begin
      failures++;
      $display("FAIL attn_early got=%b exp=0", r_attn);
    end
    idle(1);
    checks++;
    if (r_attn !== 1'b1) begin
      failures++;
      $display("FAIL attn_rise got=%b exp=1", r_attn);
    end
    strobe(4'h2);
    nib_q.push_back(4'h8);
    e = nib_q.pop_front();
    checks++;
    if (r_nib_out !== e || r_attn !== 1'b0) begin
      failures++;
      $display("FAIL attn_tc_hi got=%h/attn%b exp=%h/attn0", r_nib_out, r_attn, e);
    end
    ti_tc = 8'h82;
    idle(SYNC);
    checks++;
    if (r_attn !== 1'b1) begin
      failures++;
      $display("FAIL attn_rearm got=%b exp=1", r_attn);
    end
    strobe(4'h0);
    nib_q.push_back(4'h1);
    e = nib_q.pop_front();
    checks++;
    if (r_nib_out !== e) begin
      failures++;
      $display("FAIL attn_tc_lo got=%h exp=%h", r_nib_out, e);
    end
    strobe(4'h0);
    checks++;
    if (r_nib_oe !== 1'b0 || r_attn !== 1'b1) begin
      failures++;
      $display("FAIL attn_end got=oe%b/attn%b exp=oe0/attn1", r_nib_oe, r_attn);
    end
    $display("read  cmd=2 data=81 attn re-armed");
  endtask

  task automatic test_timeout();
    int  n    = 0;
    bit  seen = 1'b0;
    strobe(4'h6);
    strobe(4'hF);
    for (int i = 1; i <= TIMEOUT + 16; i++) begin
      @(negedge r_clk);
      if (r_err === 1'b1) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || n != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_delay got=%0d seen=%b exp=%0d", n, seen, TIMEOUT);
    end
    checks++;
    if (busy !== 1'b0 || rc_reg !== rc_m) begin
      failures++;
      $display("FAIL timeout_state got=busy%b/rc%h exp=busy0/rc%h", busy, rc_reg, rc_m);
    end
    idle(1);
    checks++;
    if (r_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse got=%b exp=0", r_err);
    end
    strobe(4'h3);
    checks++;
    if (r_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL badcmd got=err%b/busy%b exp=err1/busy0", r_err, busy);
    end
    strobe(4'h0);
    checks++;
    if (r_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nop got=err%b/busy%b exp=err0/busy0", r_err, busy);
    end
    $display("timeout after %0d cycles, bad command flagged", n);
  endtask

  task automatic test_strobe_wins();
    bit  saw_err = 1'b0;
    wr_t w;
    wr_q.push_back('{sel_rc: 1'b0, val: 8'h96});
    strobe(4'h5);
    strobe(4'h9);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      if (r_err === 1'b1) saw_err = 1'b1;
      @(negedge r_clk);
    end
    if (r_err === 1'b1) saw_err = 1'b1;
    strobe(4'h6);
    w = wr_q.pop_front();
    rd_m = w.val;
    checks++;
    if (saw_err || r_err !== 1'b0 || rd_reg !== rd_m) begin
      failures++;
      $display("FAIL strobe_wins got=err%b/%b rd%h exp=err0 rd%h",
               saw_err, r_err, rd_reg, rd_m);
    end
    $display("write cmd=5 data=96 at terminal count");
  endtask

  task automatic test_reset_midframe();
    strobe(4'h5);
    strobe(4'h7);
    r_rst = 1'b1; r_stb = 1'b1; r_nib_in = 4'h1;
    @(negedge r_clk);
    r_rst = 1'b0; r_stb = 1'b0; r_nib_in = 4'h0;
    rd_m = 8'h00; rc_m = 8'h00;
    checks++;
    if (rd_reg !== rd_m || rc_reg !== rc_m || r_err !== 1'b0 || busy !== 1'b0 ||
        r_nib_oe !== 1'b0 || r_nib_out !== 4'h0 || r_attn !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=rd%h rc%h err%b busy%b oe%b nib%h attn%b exp=all zero",
               rd_reg, rc_reg, r_err, busy, r_nib_oe, r_nib_out, r_attn);
    end
    $display("reset mid-frame");
  endtask

  task automatic test_back_to_back();
    ti_td = 8'h3C;
    idle(SYNC + 1);
    write_frame(4'h6, 8'h12, "b2b_write_rc");
    read_frame(4'h1, 8'h3C, 0, "b2b_read_td");
    checks++;
    if (rc_reg !== 8'h12 || rd_reg !== rd_m) begin
      failures++;
      $display("FAIL b2b_regs got=rc%h/rd%h exp=rc12/rd%h", rc_reg, rd_reg, rd_m);
    end
  endtask

  initial begin
    test_reset();
    test_read_td();
    test_write_rd();
    test_attn();
    test_timeout();
    test_strobe_wins();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
